// File: rtl/scan_seq_ctrl.sv
// Scan test sequencer: serial key unlock, then shift/capture patterns on request.
// All outputs are flops loaded from the next-state decode, so no input reaches
// an output without passing through a register.
module scan_seq_ctrl #(
  parameter int           CHAIN_LEN = 209,
  parameter int           CAP_CYC   = 1,
  parameter logic [7:0]   KEY       = 8'hA5
) (
  input  logic        clk,
  input  logic        srstz,
  input  logic        tst_i,
  input  logic        key_di,
  input  logic        scan_go,
  output logic        scan_mode,
  output logic        scan_en,
  output logic        capture,
  output logic        busy,
  output logic        done,
  output logic        locked,
  output logic [15:0] pat_cnt,
  output logic [9:0]  shift_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_LOCK, S_READY, S_SHIFT, S_CAPT
  } state_t;

  localparam logic [9:0] SH_LAST  = 10'(CHAIN_LEN - 1);
  localparam logic [2:0] CAP_LAST = 3'(CAP_CYC - 1);

  state_t      state, nxt;
  logic [7:0]  key_sr, key_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [2:0]  cap_cnt, cap_nxt;
  logic [9:0]  sh_nxt;
  logic [15:0] pat_nxt;
  logic        done_nxt;

  // Next-state and next-counter decode; tst_i low overrides everything.
  always_comb begin
    nxt      = state;
    key_nxt  = key_sr;
    bit_nxt  = bit_cnt;
    cap_nxt  = cap_cnt;
    sh_nxt   = '0;
    pat_nxt  = pat_cnt;
    done_nxt = 1'b0;
    if (!tst_i) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          // pat_cnt survives a tst_i drop and only clears on the way into KEY
          nxt     = S_KEY;
          key_nxt = '0;
          bit_nxt = '0;
          pat_nxt = '0;
        end
        S_KEY: begin
          key_nxt = {key_sr[6:0], key_di};
          bit_nxt = bit_cnt + 3'd1;
          // compare the shifted value so the 8th bit is included
          if (bit_cnt == 3'd7) nxt = (key_nxt == KEY) ? S_READY : S_LOCK;
        end
        S_LOCK: nxt = S_LOCK;
        S_READY: begin
          if (scan_go) nxt = S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_cnt == SH_LAST) begin
            nxt     = S_CAPT;
            cap_nxt = '0;
          end else begin
            sh_nxt = shift_cnt + 10'd1;
          end
        end
        S_CAPT: begin
          if (cap_cnt == CAP_LAST) begin
            nxt      = S_READY;
            done_nxt = 1'b1;
            if (pat_cnt != 16'hFFFF) pat_nxt = pat_cnt + 16'd1;
          end else begin
            cap_nxt = cap_cnt + 3'd1;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      state     <= S_IDLE;
      key_sr    <= '0;
      bit_cnt   <= '0;
      cap_cnt   <= '0;
      scan_mode <= 1'b0;
      scan_en   <= 1'b0;
      capture   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      pat_cnt   <= '0;
      shift_cnt <= '0;
    end else begin
      state     <= nxt;
      key_sr    <= key_nxt;
      bit_cnt   <= bit_nxt;
      cap_cnt   <= cap_nxt;
      scan_mode <= (nxt == S_READY) || (nxt == S_SHIFT) || (nxt == S_CAPT);
      scan_en   <= (nxt == S_SHIFT);
      capture   <= (nxt == S_CAPT);
      busy      <= (nxt == S_SHIFT) || (nxt == S_CAPT);
      done      <= done_nxt;
      locked    <= (nxt == S_LOCK);
      pat_cnt   <= pat_nxt;
      shift_cnt <= sh_nxt;
    end
  end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: unlock, wrong key, single pattern,
// back-to-back patterns, abort, async reset mid-capture.
module tb_scan_seq_ctrl;

  logic        clk, srstz, tst_i, key_di, scan_go;
  logic        scan_mode, scan_en, capture, busy, done, locked;
  logic [15:0] pat_cnt;
  logic [9:0]  shift_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  scan_seq_ctrl #(.CHAIN_LEN(209), .CAP_CYC(1), .KEY(8'hA5)) dut (
    .clk(clk), .srstz(srstz), .tst_i(tst_i), .key_di(key_di), .scan_go(scan_go),
    .scan_mode(scan_mode), .scan_en(scan_en), .capture(capture), .busy(busy),
    .done(done), .locked(locked), .pat_cnt(pat_cnt), .shift_cnt(shift_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // inputs change on negedge; one call = one rising edge, then sample
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_key(input logic [7:0] k);
    for (int i = 7; i >= 0; i--) begin
      key_di = k[i];
      step();
    end
    key_di = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {scan_mode, scan_en, capture, busy, done, locked, pat_cnt, shift_cnt};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int en_n, cap_n, busy_n, done_n, done_k, ovl, sh100, d1, d2, k;
    bit got;
    srstz = 1'b0; tst_i = 1'b0; key_di = 1'b0; scan_go = 1'b0;

    // reset state before any clock edge
    #3;
    chk("reset_outs", outs(), 32'h0);
    step();
    srstz = 1'b1;
    step();
    chk("idle_outs", outs(), 32'h0);

    // key unlock: READY on the 9th edge after tst_i is sampled
    tst_i = 1'b1;
    step();
    chk("key_entry_mode", {31'h0, scan_mode}, 32'h0);
    for (int i = 7; i >= 0; i--) begin
      key_di = ((8'hA5 >> i) & 8'h1) != 0;
      step();
      if (i == 1) chk("key_7bits_mode", {31'h0, scan_mode}, 32'h0);
    end
    chk("unlock_mode", {31'h0, scan_mode}, 32'h1);
    chk("unlock_locked", {31'h0, locked}, 32'h0);
    chk("ready_scan_en", {31'h0, scan_en}, 32'h0);

    // single pattern
    scan_go = 1'b1;
    step();
    scan_go = 1'b0;
    chk("go_latency_en", {31'h0, scan_en}, 32'h1);
    chk("first_shift_cnt", {22'h0, shift_cnt}, 32'h0);
    en_n = 1; cap_n = 0; busy_n = 1; done_n = 0; done_k = -1; ovl = 0; sh100 = -1;
    for (k = 1; k < 260; k++) begin
      step();
      en_n   += scan_en;
      cap_n  += capture;
      busy_n += busy;
      if (scan_en && capture) ovl++;
      if (k == 100) sh100 = shift_cnt;
      if (done) begin done_n++; done_k = k; end
    end
    chk("shift_cnt_100", sh100, 100);
    chk("scan_en_cycles", en_n, 209);
    chk("capture_cycles", cap_n, 1);
    chk("busy_cycles", busy_n, 210);
    chk("en_cap_overlap", ovl, 0);
    chk("done_pulses", done_n, 1);
    chk("done_latency", done_k, 210);
    chk("pat_cnt_1", {16'h0, pat_cnt}, 32'h1);
    chk("ready_shift_cnt", {22'h0, shift_cnt}, 32'h0);

    // back-to-back with scan_go held high
    scan_go = 1'b1;
    d1 = -1; d2 = -1; got = 1'b0;
    for (k = 0; k < 700 && !got; k++) begin
      step();
      if (done) begin
        if (d1 < 0) d1 = k; else d2 = k;
        chk("done_cycle_scan_en", {31'h0, scan_en}, 32'h0);
      end
      if (d2 >= 0 && scan_en && shift_cnt == 10'd100) got = 1'b1;
    end
    chk("b2b_reached", {31'h0, got}, 32'h1);
    chk("done_spacing", d2 - d1, 211);
    chk("pat_cnt_3", {16'h0, pat_cnt}, 32'h3);

    // abort mid-SHIFT at shift_cnt=100
    tst_i = 1'b0; scan_go = 1'b0;
    step();
    chk("abort_outs", outs(), {6'b000000, 16'h0003, 10'h000});
    done_n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      done_n += done;
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_pat_hold", {16'h0, pat_cnt}, 32'h3);

    // wrong key -> LOCK, scan_go ignored
    tst_i = 1'b1;
    step();
    chk("key_entry_clr_pat", {16'h0, pat_cnt}, 32'h0);
    send_key(8'hA4);
    chk("wrong_locked", {31'h0, locked}, 32'h1);
    chk("wrong_mode", {31'h0, scan_mode}, 32'h0);
    en_n = 0; busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      scan_go = (i % 2) == 0;
      step();
      en_n += scan_en; busy_n += busy;
    end
    scan_go = 1'b0;
    chk("lock_go_ignored_en", en_n, 0);
    chk("lock_go_ignored_busy", busy_n, 0);
    chk("lock_hold", {31'h0, locked}, 32'h1);
    tst_i = 1'b0;
    step();
    chk("lock_release", {31'h0, locked}, 32'h0);

    // async reset mid-CAPT
    tst_i = 1'b1;
    step();
    send_key(8'hA5);
    chk("relock_mode", {31'h0, scan_mode}, 32'h1);
    scan_go = 1'b1;
    step();
    scan_go = 1'b0;
    got = 1'b0;
    for (k = 0; k < 300 && !got; k++) begin
      step();
      if (capture) got = 1'b1;
    end
    chk("reached_capt", {31'h0, got}, 32'h1);
    #2 srstz = 1'b0;
    #1 chk("async_reset_outs", outs(), 32'h0);
    step();
    step();
    chk("reset_held_outs", outs(), 32'h0);
    srstz = 1'b1;
    step();
    chk("post_reset_mode", {31'h0, scan_mode}, 32'h0);
    send_key(8'hA5);
    chk("post_reset_unlock", {31'h0, scan_mode}, 32'h1);
    chk("post_reset_pat", {16'h0, pat_cnt}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
